// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage latches: occupancy width, the
// (main_v, skid_v) state encoding and per-boundary default widths.
package pipe_pkg;

  localparam int OCC_W = 2;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_TWO   = 2'b11;

  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 106;
  localparam int IDEX_CTRL_W  = 9;
  localparam int EXMEM_DATA_W = 69;
  localparam int EXMEM_CTRL_W = 6;
  localparam int MEMWB_DATA_W = 32;
  localparam int MEMWB_CTRL_W = 4;

  function automatic logic [OCC_W-1:0] occupancy(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline latch: valid flag plus payload and control,
// with independent valid write, payload load and flush clear.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              v_we,
  input  logic              v_d,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  input  logic [CTRL_W-1:0] c,
  output logic              v_q,
  output logic [DATA_W-1:0] d_q,
  output logic [CTRL_W-1:0] c_q
);

  // NOTE: sequential state uses non-blocking assignments so every slot samples
  // pre-edge values, which is what makes the skid->main move race-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
      c_q <= '0;
    end else if (clear) begin
      // Payload is left stale on flush; only control must never leak.
      v_q <= 1'b0;
      c_q <= '0;
    end else begin
      if (v_we) v_q <= v_d;
      if (load) begin
        d_q <= d;
        c_q <= c;
      end
    end
  end

endmodule

// File: rtl/pipe_latch_skid.sv
// Parametrised inter-stage latch with valid/ready handshake, optional 2-entry
// skid buffer, flush, debug enable and control masking of bubbles.
module pipe_latch_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [OCC_W-1:0]  o_count
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic [CTRL_W-1:0] main_c, skid_c;

  logic in_fire, out_fire;
  logic main_load, main_from_skid, main_v_we, main_v_d;
  logic skid_load, skid_v_we, skid_v_d;
  logic [1:0] state;

  assign state    = {main_v, skid_v};
  assign out_fire = main_v & i_ready & i_enable;
  assign in_fire  = i_valid & o_ready;

  // SKID=1 keeps i_ready off the o_ready path; SKID=0 trades that for one slot.
  generate
    if (SKID) begin : g_ready_skid
      assign o_ready = ~skid_v & i_enable;
    end else begin : g_ready_comb
      assign o_ready = i_enable & (~main_v | i_ready);
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_v_we      = 1'b0;
    main_v_d       = main_v;
    skid_load      = 1'b0;
    skid_v_we      = 1'b0;
    skid_v_d       = skid_v;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          main_v_we = 1'b1;
          main_v_d  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && !out_fire) begin
          skid_load = 1'b1;
          skid_v_we = 1'b1;
          skid_v_d  = 1'b1;
        end else if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (out_fire) begin
          main_v_we = 1'b1;
          main_v_d  = 1'b0;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_v_we      = 1'b1;
          skid_v_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (i_flush),
    .v_we  (main_v_we),
    .v_d   (main_v_d),
    .load  (main_load),
    .d     (main_from_skid ? skid_d : i_data),
    .c     (main_from_skid ? skid_c : i_ctrl),
    .v_q   (main_v),
    .d_q   (main_d),
    .c_q   (main_c)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (i_flush),
        .v_we  (skid_v_we),
        .v_d   (skid_v_d),
        .load  (skid_load),
        .d     (i_data),
        .c     (i_ctrl),
        .v_q   (skid_v),
        .d_q   (skid_d),
        .c_q   (skid_c)
      );
    end else begin : g_no_skid
      logic unused_skid;
      assign skid_v      = 1'b0;
      assign skid_d      = '0;
      assign skid_c      = '0;
      assign unused_skid = ^{skid_load, skid_v_we, skid_v_d};
    end
  endgenerate

  assign o_valid = main_v;
  assign o_data  = main_d;
  assign o_ctrl  = main_v ? main_c : '0;
  assign o_count = occupancy(main_v, skid_v);

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Scoreboard bench: a queue-based model per variant (capacity 2 with skid,
// 1 without) predicts the head entry, occupancy and readiness every cycle.
module tb_pipe_latch_skid;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, i_flush, i_valid, i_ready;
  logic [31:0] i_data;
  logic [3:0]  i_ctrl;

  logic        o_ready1, o_valid1, o_ready0, o_valid0;
  logic [31:0] o_data1, o_data0;
  logic [3:0]  o_ctrl1, o_ctrl0;
  logic [1:0]  o_count1, o_count0;

  int checks   = 0;
  int failures = 0;
  int max1     = 0;

  ent_t        q1[$];
  ent_t        q0[$];
  logic [31:0] del1[$];

  always #5 clk = ~clk;

  pipe_latch_skid #(.DATA_W(32), .CTRL_W(4), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready1), .i_data(i_data), .i_ctrl(i_ctrl),
    .o_valid(o_valid1), .i_ready(i_ready), .o_data(o_data1), .o_ctrl(o_ctrl1),
    .o_count(o_count1)
  );

  pipe_latch_skid #(.DATA_W(32), .CTRL_W(4), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready0), .i_data(i_data), .i_ctrl(i_ctrl),
    .o_valid(o_valid0), .i_ready(i_ready), .o_data(o_data0), .o_ctrl(o_ctrl0),
    .o_count(o_count0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bounded FIFOs updated from the handshake rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin : model
      bit acc1, acc0, pop1, pop0;
      acc1 = i_valid && i_enable && (q1.size() < 2);
      acc0 = i_valid && i_enable && (q0.size() == 0 || i_ready);
      pop1 = i_enable && i_ready && (q1.size() > 0);
      pop0 = i_enable && i_ready && (q0.size() > 0);
      if (pop1) void'(q1.pop_front());
      if (pop0) void'(q0.pop_front());
      if (i_flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (acc1) q1.push_back('{d: i_data, c: i_ctrl});
        if (acc0) q0.push_back('{d: i_data, c: i_ctrl});
      end
    end
  end

  // Monitor: compare DUT outputs to the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("valid1", o_valid1, q1.size() > 0);
      check("count1", o_count1, q1.size());
      check("ready1", o_ready1, i_enable && (q1.size() < 2));
      if (q1.size() > 0) begin
        check("data1", o_data1, q1[0].d);
        check("ctrl1", o_ctrl1, q1[0].c);
      end else begin
        check("ctrl1_mask", o_ctrl1, 0);
      end
      check("valid0", o_valid0, q0.size() > 0);
      check("count0", o_count0, q0.size());
      check("ready0", o_ready0, i_enable && (q0.size() == 0 || i_ready));
      if (q0.size() > 0) begin
        check("data0", o_data0, q0[0].d);
        check("ctrl0", o_ctrl0, q0[0].c);
      end else begin
        check("ctrl0_mask", o_ctrl0, 0);
      end
      if (o_valid1 && i_ready && i_enable) del1.push_back(o_data1);
      if (int'(o_count1) > max1) max1 = int'(o_count1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] c);
    i_valid = 1'b1;
    i_data  = d;
    i_ctrl  = c;
    step(1);
    i_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
    i_ready = 1'b0; i_data = '0; i_ctrl = '0;
    #12;
    check("rst_valid", o_valid1, 0);
    check("rst_ctrl", o_ctrl1, 0);
    check("rst_data", o_data1, 0);
    check("rst_count", o_count1, 0);
    check("rst_ready", o_ready1, 1);
    @(posedge clk); #1 rst = 1'b0;

    // Stream with i_ready held high
    i_ready = 1'b1; del1.delete(); max1 = 0;
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1; i_data = 32'h1000 + k; i_ctrl = 4'b0101;
      step(1);
    end
    i_valid = 1'b0;
    step(2);
    check("stream_len", del1.size(), 8);
    for (int k = 0; k < 8 && k < del1.size(); k++) check("stream_seq", del1[k], 32'h1000 + k);
    check("stream_max_count", max1, 1);

    // Backpressure fills the skid
    i_ready = 1'b0;
    send(32'hA, 4'h3);
    send(32'hB, 4'h6);
    step(1);
    check("bp_count", o_count1, 2);
    check("bp_ready", o_ready1, 0);
    check("skid0_ready_lo", o_ready0, 0);
    i_ready = 1'b1; #1;
    check("skid0_ready_hi", o_ready0, 1);
    del1.delete();
    step(3);
    check("bp_len", del1.size(), 2);
    if (del1.size() == 2) begin
      check("bp_first", del1[0], 32'hA);
      check("bp_second", del1[1], 32'hB);
    end

    // Flush while full, with a same-cycle incoming entry
    i_ready = 1'b0;
    send(32'h11, 4'h1);
    send(32'h22, 4'h2);
    i_valid = 1'b1; i_data = 32'hC; i_ctrl = 4'hF; i_flush = 1'b1;
    step(1);
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_valid", o_valid1, 0);
    check("flush_ctrl", o_ctrl1, 0);
    check("flush_count", o_count1, 0);
    i_ready = 1'b1; del1.delete();
    step(3);
    check("flush_nothing_out", del1.size(), 0);

    // Debug freeze with an entry held
    i_ready = 1'b0;
    send(32'h55, 4'h9);
    i_enable = 1'b0; i_ready = 1'b1; del1.delete();
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("freeze_data", o_data1, 32'h55);
      check("freeze_ready", o_ready1, 0);
    end
    check("freeze_no_out", del1.size(), 0);
    i_enable = 1'b1;
    step(3);
    check("freeze_once", del1.size(), 1);
    if (del1.size() == 1) check("freeze_value", del1[0], 32'h55);

    // Bubbles with all control bits high, then async reset mid-stream
    i_valid = 1'b0; i_ctrl = 4'hF;
    step(3);
    i_ready = 1'b0;
    send(32'h77, 4'hE);
    send(32'h78, 4'hD);
    check("pre_rst_valid", o_valid1, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid1", o_valid1, 0);
    check("arst_ctrl1", o_ctrl1, 0);
    check("arst_count1", o_count1, 0);
    check("arst_valid0", o_valid0, 0);
    check("arst_ctrl0", o_ctrl0, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      i_valid  = ($urandom_range(3) != 0);
      i_ready  = ($urandom_range(2) != 0);
      i_enable = ($urandom_range(7) != 0);
      i_flush  = ($urandom_range(29) == 0);
      i_data   = $urandom;
      i_ctrl   = 4'($urandom_range(15));
      step(1);
    end
    i_valid = 1'b0; i_flush = 1'b0; i_enable = 1'b1; i_ready = 1'b1;
    step(3);
    check("drain_count1", o_count1, 0);
    check("drain_count0", o_count0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
